// File: rtl/cpu_status_unit_pkg.sv
// Shared types for the 6502 status unit: flag command encoding, P bit positions,
// and the branch-condition flag selector.
package cpu_status_unit_pkg;

  typedef enum logic [3:0] {
    FOP_NONE = 4'd0,
    FOP_NZ   = 4'd1,
    FOP_NZC  = 4'd2,
    FOP_NZCV = 4'd3,
    FOP_BIT  = 4'd4,
    FOP_CLC  = 4'd5,
    FOP_SEC  = 4'd6,
    FOP_CLI  = 4'd7,
    FOP_SEI  = 4'd8,
    FOP_CLD  = 4'd9,
    FOP_SED  = 4'd10,
    FOP_CLV  = 4'd11,
    FOP_PLP  = 4'd12,
    FOP_INT  = 4'd13
  } flag_op_e;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [1:0] COND_N = 2'b00;
  localparam logic [1:0] COND_V = 2'b01;
  localparam logic [1:0] COND_C = 2'b10;
  localparam logic [1:0] COND_Z = 2'b11;

endpackage

// File: rtl/cpu_status_unit_bcd_adjust.sv
// Nibble-wise BCD correction of a binary ALU result; purely combinational.
// Each nibble wraps on its own: no carry crosses from low to high nibble.
module cpu_status_unit_bcd_adjust (
  input  logic [7:0] alu_out,
  input  logic       hc,
  input  logic       co,
  input  logic       sub,
  output logic [7:0] adj_out
);

  logic [3:0] lo_delta;
  logic [3:0] hi_delta;

  // Subtracting 6 in a 4-bit nibble is the same as adding 0xA.
  always_comb begin
    lo_delta = 4'h0;
    hi_delta = 4'h0;
    if (sub) begin
      if (!hc) lo_delta = 4'hA;
      if (!co) hi_delta = 4'hA;
    end else begin
      if (hc) lo_delta = 4'h6;
      if (co) hi_delta = 4'h6;
    end
  end

  assign adj_out = {alu_out[7:4] + hi_delta, alu_out[3:0] + lo_delta};

endmodule

// File: rtl/cpu_status_unit.sv
// 6502 processor status register P, decimal adjust of the ALU result, branch
// condition evaluation and the one-instruction-delayed IRQ mask.
module cpu_status_unit
  import cpu_status_unit_pkg::*;
#(
  parameter bit CMOS_DECIMAL = 1'b0,
  parameter bit RESET_D      = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       rdy,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_hc,
  input  logic       adj_sub,
  input  logic [3:0] flag_op,
  input  logic [7:0] db_in,
  input  logic       sync,
  input  logic       php_brk,
  input  logic [2:0] cond_sel,
  output logic [7:0] adj_out,
  output logic [7:0] p_out,
  output logic       d_flag,
  output logic       c_flag,
  output logic       irq_mask,
  output logic       cond_true
);

  logic n_r, v_r, d_r, i_r, z_r, c_r;
  logic [7:0] bcd_out;
  logic adj_en, n_src, z_src, sel_flag, upd_en;
  flag_op_e op;

  assign op     = flag_op_e'(flag_op);
  assign upd_en = clk_en && rdy;

  cpu_status_unit_bcd_adjust u_bcd (
    .alu_out (alu_out),
    .hc      (alu_hc),
    .co      (alu_co),
    .sub     (adj_sub),
    .adj_out (bcd_out)
  );

  assign adj_en  = d_r && (op == FOP_NZCV);
  assign adj_out = adj_en ? bcd_out : alu_out;

  // CMOS parts derive N/Z from the corrected result in decimal mode.
  assign n_src = (CMOS_DECIMAL && d_r) ? adj_out[7] : alu_n;
  assign z_src = (CMOS_DECIMAL && d_r) ? (adj_out == 8'h00) : alu_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_r      <= 1'b0;
      v_r      <= 1'b0;
      d_r      <= RESET_D;
      i_r      <= 1'b1;
      z_r      <= 1'b0;
      c_r      <= 1'b0;
      irq_mask <= 1'b1;
    end else if (upd_en) begin
      // Sample I before this cycle's flag update takes effect.
      if (sync) irq_mask <= i_r;
      case (op)
        FOP_NZ:   begin n_r <= n_src; z_r <= z_src; end
        FOP_NZC:  begin n_r <= n_src; z_r <= z_src; c_r <= alu_co; end
        FOP_NZCV: begin n_r <= n_src; z_r <= z_src; c_r <= alu_co; v_r <= alu_v; end
        FOP_BIT:  begin n_r <= db_in[P_N]; v_r <= db_in[P_V]; z_r <= alu_z; end
        FOP_CLC:  c_r <= 1'b0;
        FOP_SEC:  c_r <= 1'b1;
        FOP_CLI:  i_r <= 1'b0;
        FOP_SEI:  i_r <= 1'b1;
        FOP_CLD:  d_r <= 1'b0;
        FOP_SED:  d_r <= 1'b1;
        FOP_CLV:  v_r <= 1'b0;
        FOP_PLP: begin
          n_r <= db_in[P_N];
          v_r <= db_in[P_V];
          d_r <= db_in[P_D];
          i_r <= db_in[P_I];
          z_r <= db_in[P_Z];
          c_r <= db_in[P_C];
        end
        FOP_INT: begin
          i_r      <= 1'b1;
          irq_mask <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic unused_db;
  assign unused_db = ^{db_in[P_U], db_in[P_B]};

  always_comb begin
    p_out      = 8'h00;
    p_out[P_N] = n_r;
    p_out[P_V] = v_r;
    p_out[P_U] = 1'b1;
    p_out[P_B] = php_brk;
    p_out[P_D] = d_r;
    p_out[P_I] = i_r;
    p_out[P_Z] = z_r;
    p_out[P_C] = c_r;
  end

  assign d_flag = d_r;
  assign c_flag = c_r;

  always_comb begin
    case (cond_sel[2:1])
      COND_N:  sel_flag = n_r;
      COND_V:  sel_flag = v_r;
      COND_C:  sel_flag = c_r;
      COND_Z:  sel_flag = z_r;
      default: sel_flag = n_r;
    endcase
  end

  assign cond_true = (sel_flag == cond_sel[0]);

endmodule
